// File: rtl/cdma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdma_pkg
// Brief    : Shared LFSR constants, tap masks and FSM state type for the
//            gold-code CDMA spreading controller.
// Revision : 1.0 - initial release
// ============================================================================
package cdma_pkg;

    localparam int LFSR_W = 5;

    // Feedback is the parity of the tapped bits; bit 0 receives it.
    localparam logic [LFSR_W-1:0] TAP_A = 5'b11110;
    localparam logic [LFSR_W-1:0] TAP_B = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SPREAD = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] state,
        input logic [LFSR_W-1:0] taps
    );
        return {state[LFSR_W-2:0], ^(state & taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gold_gen.sv
`default_nettype none
// ============================================================================
// Module   : gold_gen
// Brief    : Pair of 5-bit LFSRs with shared load/advance, gold = A[4]^B[4].
// Revision : 1.0 - initial release
// ============================================================================
module gold_gen
    import cdma_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic              gold
);

    logic [LFSR_W-1:0] r_lfsr_a;
    logic [LFSR_W-1:0] r_lfsr_b;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr_a <= '0;
            r_lfsr_b <= '0;
        end else if (load) begin
            r_lfsr_a <= seed;
            r_lfsr_b <= seed;
        end else if (advance) begin
            r_lfsr_a <= lfsr_step(r_lfsr_a, TAP_A);
            r_lfsr_b <= lfsr_step(r_lfsr_b, TAP_B);
        end
    end

    assign gold = r_lfsr_a[LFSR_W-1] ^ r_lfsr_b[LFSR_W-1];

endmodule
`default_nettype wire

// File: rtl/cdma_spread_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cdma_spread_ctrl
// Brief    : Frame-level CDMA transmit controller: fetches payload bits and
//            spreads each over CHIPS_PER_BIT gold-code chips at clk/CHIP_DIV.
// Revision : 1.0 - initial release
// ============================================================================
module cdma_spread_ctrl
    import cdma_pkg::*;
#(
    parameter int                CHIPS_PER_BIT = 31,
    parameter int                FRAME_BITS    = 8,
    parameter int                CHIP_DIV      = 4,
    parameter logic [LFSR_W-1:0] SEED_RST      = 5'b11111
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              seed_we_i,
    input  logic              start_i,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    output logic              bit_ready_o,
    output logic              chip_o,
    output logic              chip_valid_o,
    output logic              chip_stb_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              seed_err_o,
    output logic              underrun_o
);

    localparam int DIV_W  = (CHIP_DIV > 1)   ? $clog2(CHIP_DIV)   : 1;
    localparam int CHIP_W = $clog2(CHIPS_PER_BIT);
    localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CHIP_DIV - 1);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CHIPS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LFSR_W-1:0]  r_seed;
    logic [DIV_W-1:0]   r_div;
    logic [CHIP_W-1:0]  r_chip;
    logic [BIT_W-1:0]   r_bit;
    logic               r_cur_bit;
    logic               r_underrun;

    logic [LFSR_W-1:0]  w_eff_seed;
    logic               w_seed_zero;
    logic               w_spread;
    logic               w_div_last;
    logic               w_advance;
    logic               w_bit_end;
    logic               w_frame_end;
    logic               w_bit_ready;
    logic               w_gold;

    // A seed written in the same cycle as start_i is the one checked and used.
    assign w_eff_seed  = seed_we_i ? seed_i : r_seed;
    assign w_seed_zero = (w_eff_seed == '0);

    assign w_spread    = (r_state == ST_SPREAD);
    assign w_div_last  = (r_div == DIV_LAST);
    assign w_advance   = w_spread && w_div_last;
    assign w_bit_end   = w_advance && (r_chip == CHIP_LAST);
    assign w_frame_end = w_bit_end && (r_bit == BIT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start_i && !w_seed_zero) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_SPREAD;
            ST_SPREAD: if (w_frame_end) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o       = 1'b0;
        w_bit_ready  = 1'b0;
        chip_valid_o = 1'b0;
        chip_stb_o   = 1'b0;
        chip_o       = 1'b0;
        frame_done_o = 1'b0;
        seed_err_o   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                seed_err_o = start_i && w_seed_zero;
            end
            ST_LOAD: begin
                busy_o      = 1'b1;
                w_bit_ready = 1'b1;
            end
            ST_SPREAD: begin
                busy_o       = 1'b1;
                chip_valid_o = 1'b1;
                chip_stb_o   = (r_div == '0);
                chip_o       = r_cur_bit ^ w_gold;
                // The final bit of the frame has no successor to fetch.
                w_bit_ready  = w_bit_end && (r_bit != BIT_LAST);
            end
            ST_DONE: begin
                busy_o       = 1'b1;
                frame_done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bit_ready_o = w_bit_ready;
    assign underrun_o  = r_underrun;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_seed <= SEED_RST;
        end else if (seed_we_i) begin
            r_seed <= seed_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div  <= '0;
            r_chip <= '0;
            r_bit  <= '0;
        end else if (r_state == ST_LOAD) begin
            r_div  <= '0;
            r_chip <= '0;
            r_bit  <= '0;
        end else if (w_spread) begin
            r_div <= w_div_last ? '0 : r_div + 1'b1;
            if (w_advance) begin
                r_chip <= (r_chip == CHIP_LAST) ? '0 : r_chip + 1'b1;
            end
            if (w_bit_end && (r_bit != BIT_LAST)) begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    // A missing bit is spread as zero; timing never stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cur_bit  <= 1'b0;
            r_underrun <= 1'b0;
        end else if (w_bit_ready) begin
            r_cur_bit <= bit_valid_i & bit_i;
            if (!bit_valid_i) begin
                r_underrun <= 1'b1;
            end
        end
    end

    gold_gen u_gold_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (r_state == ST_LOAD),
        .advance (w_advance),
        .seed    (r_seed),
        .gold    (w_gold)
    );

endmodule
`default_nettype wire

// File: doc/cdma_spread_ctrl.md
Name: cdma_spread_ctrl

Overview:
Frame-level transmit controller for the gold-code CDMA spreader. It accepts data bits over a valid/ready handshake and (re)loads both 5-bit LFSRs from a programmable seed at every frame start. Each bit is spread over CHIPS_PER_BIT chips at a chip rate of clk/CHIP_DIV, emitting a strobed chip stream. It sits between the payload source and the line/modulator and owns all LFSR sequencing.

Parameters:
CHIPS_PER_BIT, 31, chips per data bit (>=2)
FRAME_BITS, 8, data bits per frame (>=1)
CHIP_DIV, 4, clock cycles per chip (>=1)
SEED_RST, 5'b11111, reset value of seed shadow register

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
seed_i  in  5  seed for both LFSRs
seed_we_i  in  1  write seed_i into shadow register
start_i  in  1  request frame start
bit_i  in  1  payload bit
bit_valid_i  in  1  payload bit valid
bit_ready_o  out  1  controller fetching a bit
chip_o  out  1  spread chip (bit ^ gold)
chip_valid_o  out  1  chip_o meaningful
chip_stb_o  out  1  first cycle of each chip
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse at frame end
seed_err_o  out  1  one-cycle pulse: start rejected, zero seed
underrun_o  out  1  sticky: bit not available at fetch

Behaviour:
- Reset rst_i, asynchronous, active-high; clock clk_i. Reset forces IDLE and clears counters and LFSRs; seed shadow = SEED_RST; all outputs 0. Reset mid-frame aborts with no frame_done_o.
- LFSR A: feedback A[4]^A[3]^A[2]^A[1]; LFSR B: feedback B[4]^B[1]; both shift left, feedback into bit 0. gold = A[4]^B[4].
- Seed shadow: written on seed_we_i in any state; sampled only in LOAD. If seed_we_i and start_i coincide in IDLE, the new seed is used (bypass).
- FSM IDLE -> LOAD -> SPREAD -> DONE -> IDLE.
- IDLE: busy_o=0. start_i=1 with effective seed !=0 -> LOAD. With seed ==0 -> stay IDLE, seed_err_o pulse. start_i outside IDLE is ignored.
- LOAD (1 cycle): both LFSRs load the seed; bit/chip/div counters cleared; bit_ready_o=1.
- SPREAD: div counter 0..CHIP_DIV-1, chip counter 0..CHIPS_PER_BIT-1, bit counter 0..FRAME_BITS-1. chip_valid_o=1 throughout. chip_stb_o=1 when div==0. chip_o = cur_bit ^ gold, held for CHIP_DIV cycles. LFSRs advance on div==CHIP_DIV-1. LFSRs are not reset between bits, only per frame.
- Bit fetch: bit_ready_o=1 in LOAD and on the last cycle of the last chip of every bit except the final bit. Transfer = bit_ready_o & bit_valid_i -> cur_bit <= bit_i. If bit_valid_i=0 at a fetch, cur_bit <= 0, underrun_o set (cleared only by reset), and timing is unchanged (no stall).
- After the last cycle of the last chip of bit FRAME_BITS-1 -> DONE. DONE lasts 1 cycle with frame_done_o=1 and busy_o=1, then IDLE.
- Latency: start_i at cycle T -> LOAD at T+1 -> first chip_stb_o at T+2. SPREAD lasts FRAME_BITS*CHIPS_PER_BIT*CHIP_DIV cycles.
- busy_o=1 in LOAD, SPREAD and DONE. Outside SPREAD: chip_o, chip_valid_o and chip_stb_o are 0.
- CHIP_DIV=1: chip_stb_o is high on every SPREAD cycle.

Decomposition:
- cdma_pkg: LFSR_W=5, tap masks (A 5'b11110, B 5'b10010), FSM state enum.
- Sub-module gold_gen: two LFSRs with load/advance enables and a gold bit output. The controller instantiates one.

Test Plan:
- seed_i=5'b11111 loaded, start, all bits =1, CHIP_DIV=1 -> first 9 chip_o = 1,1,1,1,1,1,1,1,0 (gold 0×8 then 1). First chip_stb_o at T+2.
- Defaults, 8 bits always valid -> frame_done_o exactly 8*31*4+2 cycles after start_i, exactly 8 bit_ready_o handshakes, underrun_o=0.
- bit_valid_i low at the 3rd fetch -> bit 2 chips equal raw gold (bit 0), underrun_o=1 sticky, frame_done_o timing unchanged.
- seed_we_i with seed_i=0 then start_i -> seed_err_o one pulse, busy_o stays 0. Next, seed_we_i and start_i in the same cycle with seed 5'b10101 -> frame runs with 10101.
- seed_we_i mid-frame -> current frame chips unchanged; next frame uses the new seed. start_i mid-frame is ignored.
- rst_i asserted during SPREAD -> all outputs 0 asynchronously, no frame_done_o, seed shadow = 5'b11111.
